// File: rtl/finv_mantissa_seq_if.sv
// Handshake bundle for the reciprocal-mantissa generator: divisor in, divide-multiplier operand out.
interface finv_mantissa_seq_if #(
   parameter int unsigned W = 32
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] x2;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] y;
   logic         exc;

   // Producer/consumer side
   modport master (
      output in_valid, x2, out_ready,
      input  in_ready, out_valid, y, exc
   );

   // Reciprocal block side
   modport slave (
      input  in_valid, x2, out_ready,
      output in_ready, out_valid, y, exc
   );
endinterface

// File: rtl/finv_mantissa_seq.sv
// Sequential reciprocal-mantissa generator for the FPU divide path.
// Replaces the divisor fraction with the fraction of 2/(1.m) using bit-serial
// restoring division (one quotient bit per cycle); sign and exponent pass through.
module finv_mantissa_seq #(
   parameter int unsigned MW = 23,
   parameter int unsigned EW = 8
) (
   input logic                clk,
   input logic                rst,
   finv_mantissa_seq_if.slave bus
);
   localparam int unsigned DW = MW + 1;        // divisor / quotient width (hidden one included)
   localparam int unsigned PW = MW + 2;        // partial remainder width, holds 2.0 in Q(MW)
   localparam int unsigned CW = $clog2(DW);
   localparam int unsigned WW = 1 + EW + MW;
   localparam logic [CW-1:0] LAST = CW'(DW - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state;
   state_t          state_next;
   logic            accept;
   logic            last;

   logic [CW-1:0]   cnt;
   logic [PW-1:0]   rem;
   logic [DW-1:0]   div;
   logic [DW-1:0]   quo;
   logic            sgn;
   logic [EW-1:0]   expo;
   logic [WW-1:0]   y_r;
   logic            exc_r;

   logic            q_bit;
   logic [PW-1:0]   rem_sel;
   logic [PW-1:0]   rem_next;
   logic [DW-1:0]   quo_next;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: accept only in IDLE, 24 iterations in BUSY, hold DONE until consumed
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.in_valid) begin
               accept     = 1'b1;
               state_next = BUSY;
            end
         end
         BUSY: begin
            if (last) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // One restoring-division step; m2 = 0 saturates to all ones with no special casing
   always_comb begin
      last     = (cnt == LAST);
      q_bit    = (rem >= PW'(div));
      rem_sel  = q_bit ? (rem - PW'(div)) : rem;
      rem_next = rem_sel << 1;
      quo_next = (quo << 1) | DW'(q_bit);
   end

   // Operand capture, iteration registers and the held result word
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         rem   <= '0;
         div   <= '0;
         quo   <= '0;
         sgn   <= 1'b0;
         expo  <= '0;
         y_r   <= '0;
         exc_r <= 1'b0;
      end else if (accept) begin
         sgn  <= bus.x2[WW-1];
         expo <= bus.x2[WW-2:MW];
         div  <= {1'b1, bus.x2[MW-1:0]};
         rem  <= {1'b1, {(PW-1){1'b0}}};
         quo  <= '0;
         cnt  <= '0;
      end else if (state == BUSY) begin
         rem <= rem_next;
         quo <= quo_next;
         cnt <= cnt + CW'(1);
         if (last) begin
            y_r   <= {sgn, expo, quo_next[MW-1:0]};
            exc_r <= (expo == '0) || (expo == '1);
         end
      end
   end

   // Handshake flags decode the state register directly
   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.y         = y_r;
   assign bus.exc       = exc_r;

endmodule

// File: tb/tb_finv_mantissa_seq.sv
// Self-checking bench for finv_mantissa_seq: directed vector table, backpressure and
// mid-operation reset sequences, then random divisors against a division reference.
module tb_finv_mantissa_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   finv_mantissa_seq_if #(.W(32)) bus ();

   finv_mantissa_seq dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [31:0] x2;
      logic [31:0] y;
      logic        exc;
   } vec_t;

   vec_t        vecs[9];
   int          checks   = 0;
   int          failures = 0;
   logic [31:0] exp_y_q[$];
   logic        exp_exc_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
      end
   endtask

   function automatic logic [31:0] ref_y(input logic [31:0] x);
      longint unsigned d;
      longint unsigned q;
      d = 64'h800000 | 64'(x[22:0]);
      q = (64'd1 << 47) / d;
      if (q > 64'hFFFFFF) q = 64'hFFFFFF;
      return {x[31:23], q[22:0]};
   endfunction

   function automatic logic ref_exc(input logic [31:0] x);
      return (x[30:23] == 8'h00) || (x[30:23] == 8'hFF);
   endfunction

   // 1.m * 1.r must lie in [2 - 2^-22, 2]
   task automatic prod_chk(input logic [31:0] x, input logic [31:0] yv);
      longint unsigned d;
      longint unsigned r;
      longint unsigned p;
      d = 64'h800000 | 64'(x[22:0]);
      r = 64'h800000 | 64'(yv[22:0]);
      p = d * r;
      checks++;
      if (!((p >= (64'd1 << 47) - (64'd1 << 24)) && (p <= (64'd1 << 47)))) begin
         failures++;
         $display("FAIL product x2=%h actual=%h required_range=[%h,%h]", x, p,
                  (64'd1 << 47) - (64'd1 << 24), 64'd1 << 47);
      end
   endtask

   // Scoreboard: compare every output handshake against the oldest pending expectation
   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (exp_y_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output actual=%h required=none", bus.y);
         end else begin
            chk("y", bus.y, exp_y_q.pop_front());
            chk("exc", 32'(bus.exc), 32'(exp_exc_q.pop_front()));
         end
      end
   end

   task automatic run_op(input logic [31:0] x, input logic [31:0] ey, input logic ee,
                         input int stall, input logic early);
      int n;
      int lat;
      n = 0;
      while (!bus.in_ready && n < 64) begin
         @(posedge clk); #1;
         n++;
      end
      if (!bus.in_ready) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout actual=in_ready_low required=in_ready_high");
         return;
      end
      bus.x2        = x;
      bus.in_valid  = 1'b1;
      bus.out_ready = early;
      @(posedge clk);
      exp_y_q.push_back(ey);
      exp_exc_q.push_back(ee);
      #1;
      bus.in_valid = 1'b0;
      bus.x2       = $urandom;
      lat = 0;
      while (!bus.out_valid && lat < 64) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", 32'(lat), 32'd24);
      if (!bus.out_valid) begin
         void'(exp_y_q.pop_back());
         void'(exp_exc_q.pop_back());
         bus.out_ready = 1'b0;
         return;
      end
      prod_chk(x, bus.y);
      if (stall > 0) begin
         bus.out_ready = 1'b0;
         for (int i = 0; i < stall; i++) begin
            bus.in_valid = 1'b1;
            bus.x2       = $urandom;
            chk("stall_y", bus.y, ey);
            chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
            chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
            @(posedge clk); #1;
         end
         bus.in_valid = 1'b0;
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk("in_ready_after", 32'(bus.in_ready), 32'd1);
      chk("out_valid_after", 32'(bus.out_valid), 32'd0);
      chk("y_hold", bus.y, ey);
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] x;

      vecs[0] = '{32'h3FC00000, 32'h3FAAAAAA, 1'b0};
      vecs[1] = '{32'h40000000, 32'h407FFFFF, 1'b0};
      vecs[2] = '{32'h3FFFFFFF, 32'h3F800000, 1'b0};
      vecs[3] = '{32'hC0A00000, 32'hC0CCCCCC, 1'b0};
      vecs[4] = '{32'h7F800000, 32'h7FFFFFFF, 1'b1};
      vecs[5] = '{32'h00400000, 32'h002AAAAA, 1'b1};
      vecs[6] = '{32'h3F800000, 32'h3FFFFFFF, 1'b0};
      vecs[7] = '{32'hFF7FFFFF, 32'hFF000000, 1'b0};
      vecs[8] = '{32'h80000001, 32'h807FFFFE, 1'b1};

      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.x2        = '0;
      rst           = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_y", bus.y, 32'h0);
      chk("rst_exc", 32'(bus.exc), 32'd0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

      // Directed vectors
      for (int i = 0; i < 9; i++) begin
         run_op(vecs[i].x2, vecs[i].y, vecs[i].exc, 0, (i == 0));
      end

      // Backpressure: result held, extra inputs ignored while DONE
      run_op(32'h40400000, 32'h402AAAAA, 1'b0, 10, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("no_spurious_valid", 32'(bus.out_valid), 32'd0);

      // Reset in the middle of an operation discards it
      bus.x2       = 32'h3FC00000;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      chk("midop_busy", 32'(bus.in_ready), 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("midrst_y", bus.y, 32'h0);
      chk("midrst_exc", 32'(bus.exc), 32'd0);
      repeat (30) @(posedge clk);
      #1;
      chk("midrst_no_output", 32'(bus.out_valid), 32'd0);
      run_op(32'hC0A00000, 32'hC0CCCCCC, 1'b0, 0, 1'b1);

      // Random divisors against the division reference
      for (int i = 0; i < 1500; i++) begin
         x = $urandom;
         run_op(x, ref_y(x), ref_exc(x), 0, 1'($urandom_range(0, 1)));
      end

      repeat (5) @(posedge clk);
      #1;
      chk("queue_empty", 32'(exp_y_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
